// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
//
// Serially loads the configuration-flip-flop chain of a routing tile (or tile
// group) from bitstream words delivered over a valid/ready handshake. Each
// word is shifted MSB-first onto ccff_head with config_enable high for exactly
// one cycle per bit. The old chain contents falling out of ccff_tail are
// folded into a running parity as a cheap readback check.
//
// Ports:
//   prog_clk       configuration clock (only clock)
//   pReset         asynchronous, active-high reset
//   start          begin a load (honoured only when idle)
//   abort          terminate a load in progress
//   bs_data        bitstream word
//   bs_valid       bs_data valid
//   bs_ready       word accepted this cycle (combinational, high while fetching)
//   ccff_tail      chain tail, sampled on every shift edge
//   ccff_head      serial bit to the chain head (registered)
//   config_enable  chain shift enable, one bit per high cycle (registered)
//   busy           load in progress (registered)
//   done           one-cycle pulse on completed load (registered)
//   aborted        one-cycle pulse on abort (registered)
//   bit_cnt        bits shifted in the current or last load (registered)
//   rb_parity      XOR of ccff_tail samples in the current or last load
// ---------------------------------------------------------------------------
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 40,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  input  logic              ccff_tail,
  output logic              ccff_head,
  output logic              config_enable,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              rb_parity
);

  localparam int WC_W = $clog2(WORD_W + 1);

  localparam logic [CNT_W:0]   LAST_C      = (CNT_W + 1)'(CHAIN_LEN);
  localparam logic [CNT_W:0]   CNT_ONE_X_C = (CNT_W + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);
  localparam logic [WC_W-1:0]  WORD_LAST_C = WC_W'(WORD_W);
  localparam logic [WC_W-1:0]  WC_ONE_C    = WC_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Folds one readback sample into the running parity.
  function automatic logic parity_fold(input logic acc, input logic sample);
    return acc ^ sample;
  endfunction

  state_t            state_r,     state_nxt_s;
  logic              head_r,      head_nxt_s;
  logic              ce_r,        ce_nxt_s;
  logic              busy_r,      busy_nxt_s;
  logic              done_r,      done_nxt_s;
  logic              aborted_r,   aborted_nxt_s;
  logic [CNT_W-1:0]  bit_cnt_r,   bit_cnt_nxt_s;
  logic              parity_r,    parity_nxt_s;
  logic [WORD_W-1:0] sreg_r,      sreg_nxt_s;
  logic [WC_W-1:0]   wcnt_r,      wcnt_nxt_s;

  // Next-state and next-output logic for the load sequencer.
  always_comb begin
    state_nxt_s   = state_r;
    head_nxt_s    = head_r;
    ce_nxt_s      = ce_r;
    done_nxt_s    = 1'b0;
    aborted_nxt_s = 1'b0;
    bit_cnt_nxt_s = bit_cnt_r;
    parity_nxt_s  = parity_r;
    sreg_nxt_s    = sreg_r;
    wcnt_nxt_s    = wcnt_r;

    case (state_r)
      ST_IDLE: begin
        ce_nxt_s = 1'b0;
        if (start) begin
          state_nxt_s   = ST_FETCH;
          bit_cnt_nxt_s = '0;
          parity_nxt_s  = 1'b0;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end

      ST_FETCH: begin
        // Abort beats a simultaneous handshake: the offered word is left unconsumed.
        if (abort) begin
          state_nxt_s   = ST_IDLE;
          ce_nxt_s      = 1'b0;
          aborted_nxt_s = 1'b1;
        end else if (bs_valid) begin
          state_nxt_s = ST_SHIFT;
          head_nxt_s  = bs_data[WORD_W-1];
          ce_nxt_s    = 1'b1;
          sreg_nxt_s  = bs_data << 1'd1;
          wcnt_nxt_s  = WC_ONE_C;
        end else begin
          ce_nxt_s    = 1'b0;
        end
      end

      ST_SHIFT: begin
        if (abort) begin
          state_nxt_s   = ST_IDLE;
          ce_nxt_s      = 1'b0;
          aborted_nxt_s = 1'b1;
        end else begin
          // The chain captures ccff_head on this edge while its old tail bit is sampled.
          bit_cnt_nxt_s = bit_cnt_r + CNT_ONE_C;
          parity_nxt_s  = parity_fold(parity_r, ccff_tail);
          // Chain-length check comes first so a partial last word ends the load.
          if (({1'b0, bit_cnt_r} + CNT_ONE_X_C) == LAST_C) begin
            state_nxt_s = ST_DONE;
            ce_nxt_s    = 1'b0;
            done_nxt_s  = 1'b1;
          end else if (wcnt_r == WORD_LAST_C) begin
            state_nxt_s = ST_FETCH;
            ce_nxt_s    = 1'b0;
          end else begin
            head_nxt_s  = sreg_r[WORD_W-1];
            sreg_nxt_s  = sreg_r << 1'd1;
            wcnt_nxt_s  = wcnt_r + WC_ONE_C;
          end
        end
      end

      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        ce_nxt_s    = 1'b0;
      end

      default: begin
        state_nxt_s = ST_IDLE;
        ce_nxt_s    = 1'b0;
      end
    endcase

    busy_nxt_s = (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_SHIFT);
  end

  // State and registered outputs; pReset clears everything immediately.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_r   <= ST_IDLE;
      head_r    <= 1'b0;
      ce_r      <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      bit_cnt_r <= '0;
      parity_r  <= 1'b0;
      sreg_r    <= '0;
      wcnt_r    <= '0;
    end else begin
      state_r   <= state_nxt_s;
      head_r    <= head_nxt_s;
      ce_r      <= ce_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      aborted_r <= aborted_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      parity_r  <= parity_nxt_s;
      sreg_r    <= sreg_nxt_s;
      wcnt_r    <= wcnt_nxt_s;
    end
  end

  assign bs_ready      = (state_r == ST_FETCH);
  assign ccff_head     = head_r;
  assign config_enable = ce_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign aborted       = aborted_r;
  assign bit_cnt       = bit_cnt_r;
  assign rb_parity     = parity_r;

endmodule

// File: tb/tb_ccff_chain_loader.sv
`timescale 1ns/1ps
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 40-bit chain, 8-bit words
  logic       start40, abort40, bs_valid40, bs_ready40, tail40, head40;
  logic       ce40, busy40, done40, aborted40, rb_parity40;
  logic [7:0] bs_data40;
  logic [5:0] bit_cnt40;

  // 10-bit chain, 8-bit words (partial last word)
  logic       start10, abort10, bs_valid10, bs_ready10, tail10, head10;
  logic       ce10, busy10, done10, aborted10, rb_parity10;
  logic [7:0] bs_data10;
  logic [3:0] bit_cnt10;

  ccff_chain_loader #(.CHAIN_LEN(40), .WORD_W(8)) u_dut40 (
    .prog_clk(clk), .pReset(rst), .start(start40), .abort(abort40),
    .bs_data(bs_data40), .bs_valid(bs_valid40), .bs_ready(bs_ready40),
    .ccff_tail(tail40), .ccff_head(head40), .config_enable(ce40),
    .busy(busy40), .done(done40), .aborted(aborted40),
    .bit_cnt(bit_cnt40), .rb_parity(rb_parity40)
  );

  ccff_chain_loader #(.CHAIN_LEN(10), .WORD_W(8)) u_dut10 (
    .prog_clk(clk), .pReset(rst), .start(start10), .abort(abort10),
    .bs_data(bs_data10), .bs_valid(bs_valid10), .bs_ready(bs_ready10),
    .ccff_tail(tail10), .ccff_head(head10), .config_enable(ce10),
    .busy(busy10), .done(done10), .aborted(aborted10),
    .bit_cnt(bit_cnt10), .rb_parity(rb_parity10)
  );

  int vecs = 0;
  int errs = 0;
  logic exp40_q[$];
  logic exp10_q[$];
  int ce_cnt40 = 0, done_cnt40 = 0, abort_cnt40 = 0;
  int ce_cnt10 = 0, done_cnt10 = 0, hs10 = 0;
  time start_t = 0, done_t40 = 0, last_ce40 = 0;

  // Chain model: shifts ccff_head in at the far end when enabled; tail is the oldest bit.
  logic [39:0] chain = 40'd0;
  logic [39:0] chain_pre = 40'd0;
  logic        chain_load = 1'b0;
  always @(posedge clk) begin
    if (chain_load) chain <= chain_pre;
    else if (ce40)  chain <= {chain[38:0], head40};
  end
  assign tail40 = chain[39];
  assign tail10 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, 40-bit chain: every enabled cycle consumes one expected bit.
  always @(negedge clk) begin : mon40
    logic b;
    if (ce40) begin
      ce_cnt40++;
      last_ce40 = $time;
      if (exp40_q.size() == 0) begin
        vecs++; errs++;
        $display("FAIL head40_unexpected: config_enable high with no bit expected (head=%0b)", head40);
      end else begin
        b = exp40_q.pop_front();
        check("head40", 64'(head40), 64'(b));
      end
    end
    if (done40) begin
      done_cnt40++;
      done_t40 = $time;
    end
    if (aborted40) abort_cnt40++;
  end

  // Scoreboard monitor, 10-bit chain.
  always @(negedge clk) begin : mon10
    logic b;
    if (ce10) begin
      ce_cnt10++;
      if (exp10_q.size() == 0) begin
        vecs++; errs++;
        $display("FAIL head10_unexpected: config_enable high with no bit expected (head=%0b)", head10);
      end else begin
        b = exp10_q.pop_front();
        check("head10", 64'(head10), 64'(b));
      end
    end
    if (done10) done_cnt10++;
  end

  // Handshake counter for the 10-bit chain, sampled mid-low-phase after inputs settle.
  always begin
    @(negedge clk);
    #2;
    if (bs_valid10 && bs_ready10) hs10++;
  end

  task automatic preload(input logic [39:0] v);
    @(negedge clk);
    chain_pre  = v;
    chain_load = 1'b1;
    @(negedge clk);
    chain_load = 1'b0;
  endtask

  task automatic do_start40();
    @(negedge clk);
    start40 = 1'b1;
    start_t = $time;
    @(negedge clk);
    start40 = 1'b0;
  endtask

  task automatic wait_ready40();
    int t = 0;
    while (!bs_ready40 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("bs_ready40_wait", 64'(bs_ready40), 64'd1);
  endtask

  task automatic send40(input logic [7:0] w, input int gap);
    if (gap > 0) bs_valid40 = 1'b0;
    wait_ready40();
    for (int g = 0; g < gap; g++) begin
      check("gap_bs_ready40", 64'(bs_ready40), 64'd1);
      check("gap_ce40", 64'(ce40), 64'd0);
      @(negedge clk);
    end
    for (int i = 7; i >= 0; i--) exp40_q.push_back(w[i]);
    bs_data40  = w;
    bs_valid40 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done40();
    int t = 0;
    while (!done40 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("done40_seen", 64'(done40), 64'd1);
  endtask

  // Full 40-bit load of A5 3C FF 00 81 over a preloaded chain.
  task automatic load40(input logic [39:0] pre, input logic gapped, input logic exp_par);
    logic [39:0] words;
    words = 40'hA5_3C_FF_00_81;
    preload(pre);
    ce_cnt40 = 0; done_cnt40 = 0; abort_cnt40 = 0;
    do_start40();
    check("start_clears_bit_cnt40", 64'(bit_cnt40), 64'd0);
    check("start_clears_parity40", 64'(rb_parity40), 64'd0);
    for (int i = 0; i < 5; i++)
      send40(words[39-8*i -: 8], (gapped && (i == 1 || i == 3)) ? 3 : 0);
    bs_valid40 = 1'b0;
    wait_done40();
    @(negedge clk);
    check("done40_one_cycle", 64'(done40), 64'd0);
    check("done40_count", 64'(done_cnt40), 64'd1);
    check("ce40_count", 64'(ce_cnt40), 64'd40);
    check("bit_cnt40", 64'(bit_cnt40), 64'd40);
    check("rb_parity40", 64'(rb_parity40), 64'(exp_par));
    check("chain40_contents", 64'(chain), 64'h00_A5_3C_FF_00_81);
    check("exp40_drained", 64'(exp40_q.size()), 64'd0);
    check("busy40_after_done", 64'(busy40), 64'd0);
    check("abort40_none", 64'(abort_cnt40), 64'd0);
    if (!gapped) begin
      check("done40_latency", 64'(done_t40 - start_t), 64'd460);
      check("done40_after_last_bit", 64'(done_t40 - last_ce40), 64'd10);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1;
    start40 = 1'b0; abort40 = 1'b0; bs_valid40 = 1'b0; bs_data40 = 8'h00;
    start10 = 1'b0; abort10 = 1'b0; bs_valid10 = 1'b0; bs_data10 = 8'h00;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_head40", 64'(head40), 64'd0);
    check("rst_ce40", 64'(ce40), 64'd0);
    check("rst_bs_ready40", 64'(bs_ready40), 64'd0);
    check("rst_busy40", 64'(busy40), 64'd0);
    check("rst_done_aborted40", 64'({done40, aborted40}), 64'd0);
    check("rst_bit_cnt40", 64'(bit_cnt40), 64'd0);
    check("rst_parity40", 64'(rb_parity40), 64'd0);
    check("rst_all10", 64'({head10, ce10, bs_ready10, busy10, done10, aborted10, bit_cnt10, rb_parity10}), 64'd0);
    rst = 1'b0;

    // Reset asserted mid-shift clears outputs without waiting for a clock edge
    do_start40();
    send40(8'hA5, 0);
    bs_valid40 = 1'b0;
    repeat (3) @(negedge clk);
    check("ce40_before_reset", 64'(ce40), 64'd1);
    check("busy40_before_reset", 64'(busy40), 64'd1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_ce40", 64'(ce40), 64'd0);
    check("async_rst_busy40", 64'(busy40), 64'd0);
    check("async_rst_bit_cnt40", 64'(bit_cnt40), 64'd0);
    check("async_rst_outs40", 64'({head40, bs_ready40, done40, aborted40, rb_parity40}), 64'd0);
    exp40_q.delete();
    @(negedge clk);
    done_cnt40 = 0; abort_cnt40 = 0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("no_pulse_after_rst_done", 64'(done_cnt40), 64'd0);
    check("no_pulse_after_rst_abort", 64'(abort_cnt40), 64'd0);
    check("idle_after_rst", 64'({busy40, bs_ready40, ce40}), 64'd0);

    // Back-to-back words over a chain holding 7 ones, then gapped source over 6 ones
    load40(40'h11_0000_2207, 1'b0, 1'b1);
    load40(40'h80_0100_0F00, 1'b1, 1'b0);

    // Abort on a handshake cycle after two words (16 bits); top 16 old bits hold 3 ones
    preload(40'hE0_0000_0000);
    ce_cnt40 = 0; done_cnt40 = 0; abort_cnt40 = 0;
    do_start40();
    send40(8'hA5, 0);
    send40(8'h3C, 0);
    wait_ready40();
    bs_data40  = 8'hFF;
    bs_valid40 = 1'b1;
    abort40    = 1'b1;
    @(posedge clk);
    #1;
    abort40    = 1'b0;
    bs_valid40 = 1'b0;
    @(negedge clk);
    check("abort_ce40", 64'(ce40), 64'd0);
    check("abort_bs_ready40", 64'(bs_ready40), 64'd0);
    check("abort_pulse40", 64'(aborted40), 64'd1);
    check("abort_busy40", 64'(busy40), 64'd0);
    check("abort_bit_cnt40_held", 64'(bit_cnt40), 64'd16);
    check("abort_parity40_held", 64'(rb_parity40), 64'd1);
    @(negedge clk);
    check("abort_pulse40_one_cycle", 64'(aborted40), 64'd0);
    repeat (3) @(negedge clk);
    check("abort40_count", 64'(abort_cnt40), 64'd1);
    check("abort_word_not_shifted", 64'(ce_cnt40), 64'd16);
    check("abort_no_done", 64'(done_cnt40), 64'd0);
    check("abort_bit_cnt40_still", 64'(bit_cnt40), 64'd16);
    load40(40'h80_0100_0F00, 1'b0, 1'b0);

    // Partial last word on the 10-bit chain: FF then only the top two bits of C0
    ce_cnt10 = 0; done_cnt10 = 0; hs10 = 0;
    @(negedge clk); start10 = 1'b1;
    @(negedge clk); start10 = 1'b0;
    for (int i = 0; i < 8; i++) exp10_q.push_back(1'b1);
    bs_data10  = 8'hFF;
    bs_valid10 = 1'b1;
    @(posedge clk);
    #1;
    t = 0;
    while (!bs_ready10 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("bs_ready10_wait", 64'(bs_ready10), 64'd1);
    exp10_q.push_back(1'b1);
    exp10_q.push_back(1'b1);
    bs_data10 = 8'hC0;
    @(posedge clk);
    #1;
    bs_data10 = 8'h00;
    t = 0;
    while (!done10 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("done10_seen", 64'(done10), 64'd1);
    repeat (5) @(negedge clk);
    bs_valid10 = 1'b0;
    check("done10_count", 64'(done_cnt10), 64'd1);
    check("ce10_count", 64'(ce_cnt10), 64'd10);
    check("handshakes10", 64'(hs10), 64'd2);
    check("bit_cnt10", 64'(bit_cnt10), 64'd10);
    check("rb_parity10", 64'(rb_parity10), 64'd0);
    check("exp10_drained", 64'(exp10_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
